vga_dither_out: RTL

// Display-side consumer of the 24-bit dithered pixel stream.
// - Owns VGA raster timing.
// - Publishes the requested pixel coordinate to the upstream pixel source/dither path.
// - Realigns its sync/blank to that path's fixed latency.
// - Drives the 12-bit VGA DAC (4 MSBs/channel) with registered, blank-forced outputs.

---
 rtl/vga_dither_out.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_dither_out.sv
// vga_dither_out -- VGA raster timing and 12-bit DAC output stage for a
// 24-bit dithered pixel stream.
//
// The raster counters are published to the upstream pixel/dither path as
// hc_req/vc_req. That path returns the matching pixel PIPE_LAT pix_ce ticks
// later, so the raw active/hsync/vsync flags are delayed by the same number
// of ticks. This keeps colour and sync aligned at the registered DAC outputs.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pix_ce            pixel clock enable; nothing advances without it
//   pixel_in[23:0]    {R,G,B} bytes from upstream, PIPE_LAT ticks behind hc/vc_req
//   hc_req, vc_req    raster coordinate requested from upstream
//   req_active        requested coordinate lies in the visible area
//   frame_start       one-clock pulse on the tick that presents (0,0)
//   vga_hs, vga_vs    syncs, active level SYNC_POL
//   vga_r/g/b[3:0]    colour nibbles, forced to 0 outside the visible area

// One DAC channel: registers the top nibble of its byte, or 0 when blanked.
module vga_dac_chan (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       active,
    input  logic [3:0] msn,
    output logic [3:0] nib
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nib <= '0;
        else if (ce)
            nib <= active ? msn : 4'h0;
    end
endmodule

module vga_dither_out #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic [23:0] pixel_in,
    output logic [10:0] hc_req,
    output logic [9:0]  vc_req,
    output logic        req_active,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Timing flags are carried active-high internally; all-zero means
    // blank with both syncs inactive, which is also the reset value.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } tmg_t;

    logic [10:0] hc;
    logic [9:0]  vc;
    tmg_t        raw_t;
    tmg_t        dly_t;

    // Raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_ce) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
            end else begin
                hc <= hc + 11'd1;
            end
        end
    end

    // The counters sit at (0,0) after reset, so this pulse also covers the
    // first tick after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_start <= 1'b0;
        else
            frame_start <= pix_ce && (hc == '0) && (vc == '0);
    end

    assign hc_req     = hc;
    assign vc_req     = vc;
    assign req_active = raw_t.act;

    assign raw_t.act = (hc < H_ACT) && (vc < V_ACT);
    assign raw_t.hs  = (hc >= HS_BEG) && (hc < HS_END);
    assign raw_t.vs  = (vc >= VS_BEG) && (vc < VS_END);

    // Delay line that matches the upstream latency, clocked by pix_ce ticks.
    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign dly_t = raw_t;
        end else begin : g_dly
            tmg_t [PIPE_LAT-1:0] dly_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly_pipe <= '0;
                end else if (pix_ce) begin
                    dly_pipe[0] <= raw_t;
                    for (int i = 1; i < PIPE_LAT; i++)
                        dly_pipe[i] <= dly_pipe[i-1];
                end
            end

            assign dly_t = dly_pipe[PIPE_LAT-1];
        end
    endgenerate

    // Sync outputs, registered in the same stage as the colour nibbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else if (pix_ce) begin
            vga_hs <= dly_t.hs ? SYNC_POL : ~SYNC_POL;
            vga_vs <= dly_t.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Colour channels. Index 2/1/0 = R/G/B, and each channel takes the top
    // nibble of its byte verbatim.
    logic [2:0][3:0] chan_msn;
    logic [2:0][3:0] chan_nib;

    assign chan_msn = {pixel_in[23:20], pixel_in[15:12], pixel_in[7:4]};

    generate
        for (genvar c = 0; c < 3; c++) begin : g_chan
            vga_dac_chan u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .ce     (pix_ce),
                .active (dly_t.act),
                .msn    (chan_msn[c]),
                .nib    (chan_nib[c])
            );
        end
    endgenerate

    assign vga_r = chan_nib[2];
    assign vga_g = chan_nib[1];
    assign vga_b = chan_nib[0];
endmodule
